booth_term_sequencer: RTL



---
 rtl/booth_term_sequencer_if.sv | 34 +++
 rtl/booth_term_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/booth_term_sequencer_if.sv
// Operand/result bus of booth_term_sequencer.
// master = requester, slave = sequencer.
interface booth_term_sequencer_if #(
  parameter int WIDTH  = 29,
  parameter int DATA_W = 16
);
  localparam int PW = DATA_W + WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_*: once raised, the master keeps in_valid and the operands steady until
  // the transfer. out_*: while out_valid is high, the slave keeps product and
  // terms_used steady. Neither ready depends combinationally on its valid.
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] mcand;
  logic        [WIDTH-1:0]  dig_nz;
  logic        [WIDTH-1:0]  dig_neg;
  logic        [CW-1:0]     terms_max;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [PW-1:0]     product;
  logic        [CW-1:0]     terms_used;

  modport master (
    output in_valid, mcand, dig_nz, dig_neg, terms_max, out_ready,
    input  in_ready, out_valid, product, terms_used
  );

  modport slave (
    input  in_valid, mcand, dig_nz, dig_neg, terms_max, out_ready,
    output in_ready, out_valid, product, terms_used
  );
endinterface

// File: rtl/booth_term_sequencer.sv
// Iterative Booth term accumulator driven by the leading-digit priority enforcer.
// Optional BTS_TRUNC_FLAG_EN adds the 'truncated' output.
module booth_term_sequencer #(
  parameter int WIDTH  = 29,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  booth_term_sequencer_if.slave     bus,
  output logic [WIDTH-1:0]          pe_mask,
  input  logic [WIDTH-1:0]          pe_oh,
  input  logic                      pe_last,
  output logic [1:0]                dbg_state
`ifdef BTS_TRUNC_FLAG_EN
  ,
  output logic                      truncated
`endif
);
  localparam int PW = DATA_W + WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic signed [DATA_W-1:0] mcand_r;
  logic        [WIDTH-1:0]  dig_neg_r;
  logic        [PW-1:0]     acc;
  logic        [CW-1:0]     cnt;
  logic        [CW-1:0]     budget;
`ifdef BTS_TRUNC_FLAG_EN
  logic                     trunc_r;
`endif

  logic [PW-1:0]    mcand_ext;
  logic [PW-1:0]    term_mag;
  logic [PW-1:0]    term_s;
  logic             term_neg;
  logic [WIDTH-1:0] mask_rest;
  logic [CW-1:0]    cnt_next;

  // Only one pe_oh bit is ever set, so OR-ing the shifted copies selects one term.
  always_comb begin
    mcand_ext = {{(PW-DATA_W){mcand_r[DATA_W-1]}}, mcand_r};
    term_mag  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pe_oh[i]) term_mag = term_mag | (mcand_ext << i);
    end
    term_neg  = |(pe_oh & dig_neg_r);
    term_s    = term_neg ? (~term_mag + {{(PW-1){1'b0}}, 1'b1}) : term_mag;
    mask_rest = pe_mask & ~pe_oh;
    cnt_next  = cnt + {{(CW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      mcand_r     <= '0;
      dig_neg_r   <= '0;
      pe_mask     <= '0;
      acc         <= '0;
      cnt         <= '0;
      budget      <= '0;
`ifdef BTS_TRUNC_FLAG_EN
      trunc_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            mcand_r    <= bus.mcand;
            dig_neg_r  <= bus.dig_neg;
            pe_mask    <= bus.dig_nz;
            acc        <= '0;
            cnt        <= '0;
            budget     <= (bus.terms_max == '0) ? CW'(WIDTH) : bus.terms_max;
            in_ready_r <= 1'b0;
            state      <= S_RUN;
`ifdef BTS_TRUNC_FLAG_EN
            trunc_r    <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          acc     <= acc + term_s;
          pe_mask <= mask_rest;
          cnt     <= cnt_next;
          if (pe_last || (cnt_next == budget)) begin
            state       <= S_DONE;
            out_valid_r <= 1'b1;
`ifdef BTS_TRUNC_FLAG_EN
            // Digits left after this term can only mean the budget cut us short.
            trunc_r     <= |mask_rest;
`endif
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.product    = acc;
  assign bus.terms_used = cnt;
  assign dbg_state      = state;
`ifdef BTS_TRUNC_FLAG_EN
  assign truncated      = trunc_r;
`endif
endmodule
